// File: rtl/execute_stage_cc_if.sv
// Signal bundle between decode/hazard logic and the execute stage, plus the
// EX/MEM register outputs consumed by the memory stage.
interface execute_stage_cc_if;
  logic        RegWriteE;
  logic        ResultSrcE;
  logic        MemWriteE;
  logic        BranchE;
  logic        ALUSrcE;
  logic [3:0]  ALUControlE;
  logic [31:0] RD1E;
  logic [31:0] RD2E;
  logic [31:0] PCE;
  logic [31:0] ImmExtE;
  logic [4:0]  RDE;
  logic [1:0]  ForwardAE;
  logic [1:0]  ForwardBE;
  logic [31:0] ResultW;
  logic        FlushM;

  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM;
  logic        ResultSrcM;
  logic        MemWriteM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [4:0]  RDM;

  modport master (
    output RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE, ALUControlE,
           RD1E, RD2E, PCE, ImmExtE, RDE, ForwardAE, ForwardBE, ResultW, FlushM,
    input  PCSrcE, PCTargetE, RegWriteM, ResultSrcM, MemWriteM,
           ALUResultM, WriteDataM, RDM
  );

  modport slave (
    input  RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE, ALUControlE,
           RD1E, RD2E, PCE, ImmExtE, RDE, ForwardAE, ForwardBE, ResultW, FlushM,
    output PCSrcE, PCTargetE, RegWriteM, ResultSrcM, MemWriteM,
           ALUResultM, WriteDataM, RDM
  );
endinterface

// File: rtl/execute_stage_cc.sv
// Execute stage of the 5-stage RV32 pipeline: operand forwarding, ALU,
// branch decision/target, and the EX/MEM pipeline register.
module execute_stage_cc (
  input  logic              clk,
  input  logic              rst,
  execute_stage_cc_if.slave ex_io
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  logic [31:0] srcA;
  logic [31:0] fwdB;
  logic [31:0] srcB;
  logic [4:0]  shamt;
  logic [31:0] aluResult;
  logic        zero;

  logic        regWriteM_q,  regWriteM_d;
  logic        resultSrcM_q, resultSrcM_d;
  logic        memWriteM_q,  memWriteM_d;
  logic [31:0] aluResultM_q, aluResultM_d;
  logic [31:0] writeDataM_q, writeDataM_d;
  logic [4:0]  rdM_q,        rdM_d;

  // Forwarding from MEM uses the registered result of the previous instruction.
  always_comb begin
    srcA = ex_io.RD1E;
    case (ex_io.ForwardAE)
      FWD_WB:  srcA = ex_io.ResultW;
      FWD_MEM: srcA = aluResultM_q;
      default: srcA = ex_io.RD1E;
    endcase
  end

  always_comb begin
    fwdB = ex_io.RD2E;
    case (ex_io.ForwardBE)
      FWD_WB:  fwdB = ex_io.ResultW;
      FWD_MEM: fwdB = aluResultM_q;
      default: fwdB = ex_io.RD2E;
    endcase
  end

  assign srcB  = ex_io.ALUSrcE ? ex_io.ImmExtE : fwdB;
  assign shamt = srcB[4:0];

  always_comb begin
    aluResult = 32'h0;
    case (ex_io.ALUControlE)
      ALU_ADD:  aluResult = srcA + srcB;
      ALU_SUB:  aluResult = srcA - srcB;
      ALU_AND:  aluResult = srcA & srcB;
      ALU_OR:   aluResult = srcA | srcB;
      ALU_XOR:  aluResult = srcA ^ srcB;
      ALU_SLL:  aluResult = srcA << shamt;
      ALU_SRL:  aluResult = srcA >> shamt;
      ALU_SRA:  aluResult = $unsigned($signed(srcA) >>> shamt);
      ALU_SLT:  aluResult = ($signed(srcA) < $signed(srcB)) ? 32'h1 : 32'h0;
      ALU_SLTU: aluResult = (srcA < srcB) ? 32'h1 : 32'h0;
      default:  aluResult = 32'h0;
    endcase
  end

  assign zero            = (aluResult == 32'h0);
  assign ex_io.PCSrcE    = ex_io.BranchE & zero;
  assign ex_io.PCTargetE = ex_io.PCE + ex_io.ImmExtE;

  // A flush only squashes the control bits; data fields are don't-care then.
  always_comb begin
    regWriteM_d  = ex_io.RegWriteE;
    resultSrcM_d = ex_io.ResultSrcE;
    memWriteM_d  = ex_io.MemWriteE;
    if (ex_io.FlushM) begin
      regWriteM_d  = 1'b0;
      resultSrcM_d = 1'b0;
      memWriteM_d  = 1'b0;
    end
    aluResultM_d = aluResult;
    writeDataM_d = fwdB;
    rdM_d        = ex_io.RDE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regWriteM_q  <= 1'b0;
      resultSrcM_q <= 1'b0;
      memWriteM_q  <= 1'b0;
      aluResultM_q <= 32'h0;
      writeDataM_q <= 32'h0;
      rdM_q        <= 5'h0;
    end else begin
      regWriteM_q  <= regWriteM_d;
      resultSrcM_q <= resultSrcM_d;
      memWriteM_q  <= memWriteM_d;
      aluResultM_q <= aluResultM_d;
      writeDataM_q <= writeDataM_d;
      rdM_q        <= rdM_d;
    end
  end

  assign ex_io.RegWriteM  = regWriteM_q;
  assign ex_io.ResultSrcM = resultSrcM_q;
  assign ex_io.MemWriteM  = memWriteM_q;
  assign ex_io.ALUResultM = aluResultM_q;
  assign ex_io.WriteDataM = writeDataM_q;
  assign ex_io.RDM        = rdM_q;

endmodule

// File: doc/execute_stage_cc.md
# execute_stage_cc

Execute stage of the 32-bit five-stage RISC-V pipeline, directly downstream of the decode stage. It consumes the decode stage's E-suffixed control and data outputs, selects forwarded operands, computes the ALU result and branch decision/target, and registers the results into the EX/MEM pipeline register that feeds the memory stage. The branch redirect (`PCSrcE`, `PCTargetE`) goes back to fetch combinationally in the same cycle.

## Interface
- No parameters; datapath fixed at 32 bits, register index at 5 bits.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `RegWriteE`, `ResultSrcE`, `MemWriteE`, `BranchE`, `ALUSrcE` input 1 each: control from decode.
- `ALUControlE` input 4: ALU operation select.
- `RD1E`, `RD2E` input 32: register-file read data.
- `PCE`, `ImmExtE` input 32: instruction PC and sign-extended immediate.
- `RDE` input 5: destination register index.
- `ForwardAE`, `ForwardBE` input 2: operand forwarding selects from the hazard unit.
- `ResultW` input 32: writeback-stage result used for forwarding.
- `FlushM` input 1: insert a bubble into EX/MEM on the next edge.
- `PCSrcE` output 1: branch taken (combinational).
- `PCTargetE` output 32: branch target (combinational).
- `RegWriteM`, `ResultSrcM`, `MemWriteM` output 1 each: registered control.
- `ALUResultM`, `WriteDataM` output 32: registered ALU result and store data.
- `RDM` output 5: registered destination index.

## Operation
- Operand A: `ForwardAE` 00 → `RD1E`, 01 → `ResultW`, 10 → `ALUResultM`, 11 → `RD1E`.
- Forwarded B: same encoding on `ForwardBE` with `RD2E`.
- `SrcB` = `ALUSrcE` ? `ImmExtE` : forwarded B.
- ALU encoding on `ALUControlE`:
  - 0000 ADD; 0001 SUB; 0010 AND; 0011 OR; 0100 XOR.
  - 0101 SLL; 0110 SRL; 0111 SRA. Shift amount is `SrcB[4:0]`.
  - 1000 SLT (signed); 1001 SLTU. Both produce 32'h1 or 32'h0.
  - 1010–1111 produce 32'h0.
- All arithmetic is modulo 2^32. Overflow is ignored and no flags are exported.
- `Zero` = (ALU result == 0).
- `PCSrcE` = `BranchE` & `Zero`. Decode sets SUB for beq; the execute stage does not check this.
- `PCTargetE` = `PCE` + `ImmExtE`, modulo 2^32.
- EX/MEM register, loaded every rising edge:
  - `RegWriteM`, `ResultSrcM`, `MemWriteM` ← their E-stage inputs.
  - `ALUResultM` ← ALU result; `WriteDataM` ← forwarded B (not `SrcB`); `RDM` ← `RDE`.
- `FlushM`=1 at an edge: `RegWriteM`, `MemWriteM`, `ResultSrcM` load 0. Data fields load normally and are don't-care.
- Forwarding from `ALUResultM` uses the current registered value, i.e. the previous instruction's result.

## Timing
- Reset (`rst`=0): all M outputs clear to 0 immediately, without waiting for a clock edge. They hold 0 while `rst` is low.
- First capture is on the first rising edge after `rst` rises.
- Reset asserted mid-operation discards the in-flight instruction.
- Latency:
  - ALU/forward/branch path is combinational in the E cycle.
  - M outputs are valid one cycle after the E inputs are presented.
  - `PCSrcE`/`PCTargetE` are valid in the same cycle as the E inputs. They are unaffected by `rst` and `FlushM`, since they have no state.
- No stall input: a new instruction is accepted every cycle. Upstream bubbles arrive as all-zero control.
- `FlushM` together with a branch taken: the flush wins for the M register; `PCSrcE` still asserts.

## Test plan
- Reset: hold `rst`=0 with arbitrary inputs and toggle the clock.
  - All M outputs = 0 throughout.
  - Release `rst`, present ADD with RD1E=5, RD2E=7, RDE=3, RegWriteE=1.
  - Next edge: ALUResultM=12, RDM=3, RegWriteM=1.
- Immediate:
  - ALUSrcE=1, ImmExtE=32'hFFFFFFF7, RD1E=32'h10, ADD → ALUResultM=32'h7.
  - Same operands with SLT → 32'h0; with SLTU → 32'h1.
- Branch:
  - BranchE=1, SUB, RD1E=RD2E=32'hAB, PCE=32'h0C, ImmExtE=32'hFFFFFFF8 → PCSrcE=1, PCTargetE=32'h04 in the same cycle.
  - With RD2E=32'hAC → PCSrcE=0.
- Forwarding:
  - Cycle n: ADD producing 32'h20 into M.
  - Cycle n+1: ForwardAE=10, ForwardBE=01, ResultW=32'h3, ADD → ALUResultM=32'h23.
  - Also check WriteDataM=32'h3 with ALUSrcE=1.
- Shifts: RD1E=32'h80000000, SrcB=4 → SRA 32'hF8000000; SRL 32'h08000000; SLL 32'h0. ImmExtE=32'h24 shifts by 4, not 36.
- Flush/async reset:
  - MemWriteE=1, RegWriteE=1 with FlushM=1 → MemWriteM=0, RegWriteM=0 after the edge.
  - Pulse `rst` low between edges → M outputs clear before the next edge.
